// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a byte-enable BRAM with a registered read port.
// Stores take 1 cycle. Loads return after 2 edges, and o_ready drops while a read is pending.
module mem_access_unit #(
    parameter int RAM_DEPTH  = 512,
    parameter int ADDR_WIDTH = 32,
    localparam int RAW       = $clog2(RAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_rvalid,
    output logic [31:0]           o_rdata,
    output logic                  o_err,
    output logic [RAW-1:0]        o_waddr,
    output logic [RAW-1:0]        o_raddr,
    output logic [31:0]           o_din,
    output logic [3:0]            o_wen,
    output logic                  o_ren,
    output logic                  o_bram_rst,
    input  logic [31:0]           i_dout
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t         state;
    logic [1:0]     off_q;
    logic [1:0]     size_q;
    logic           uns_q;

    logic [1:0]     off;
    logic [RAW-1:0] word_idx;
    logic           accept;
    logic           legal;
    logic [31:0]    shifted;
    logic [31:0]    load_data;

    // Address bits above the BRAM range are dropped, so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^{i_addr[ADDR_WIDTH-1:RAW+2]};

    assign off        = i_addr[1:0];
    assign word_idx   = i_addr[RAW+1:2];
    assign o_ready    = (state == IDLE);
    assign accept     = i_req & o_ready & i_rst;
    assign legal      = (i_size == 2'b00) ||
                        (i_size == 2'b01 && !off[0]) ||
                        (i_size == 2'b10 && off == 2'b00);
    assign o_bram_rst = ~i_rst;
    assign o_waddr    = word_idx;
    assign o_raddr    = word_idx;
    assign o_ren      = accept & legal & ~i_we;

    always_comb begin
        o_wen = 4'b0000;
        o_din = i_wdata;
        case (i_size)
            2'b00:   o_din = {4{i_wdata[7:0]}};
            2'b01:   o_din = {2{i_wdata[15:0]}};
            default: o_din = i_wdata;
        endcase
        if (accept && legal && i_we) begin
            case (i_size)
                2'b00:   o_wen = 4'b0001 << off;
                2'b01:   o_wen = off[1] ? 4'b1100 : 4'b0011;
                default: o_wen = 4'b1111;
            endcase
        end
    end

    always_comb begin
        shifted = i_dout >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            o_rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    o_rvalid <= 1'b0;
                    o_err    <= accept & ~legal;
                    if (accept && legal && !i_we) begin
                        off_q  <= off;
                        size_q <= i_size;
                        uns_q  <= i_unsigned;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    o_err    <= 1'b0;
                    o_rdata  <= load_data;
                    o_rvalid <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-enable BRAM model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        o_ready, o_rvalid, o_err, o_ren, o_bram_rst;
    logic [31:0] o_rdata, o_din;
    logic [8:0]  o_waddr, o_raddr;
    logic [3:0]  o_wen;
    logic [31:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [512];

    always #5 clk = ~clk;

    mem_access_unit #(.RAM_DEPTH(512), .ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(o_ready),
        .i_we(we), .i_size(size), .i_unsigned(uns), .i_addr(addr),
        .i_wdata(wdata), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
        .o_waddr(o_waddr), .o_raddr(o_raddr), .o_din(o_din), .o_wen(o_wen),
        .o_ren(o_ren), .o_bram_rst(o_bram_rst), .i_dout(dout)
    );

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++)
            if (o_wen[n]) mem[o_waddr][8*n +: 8] <= o_din[8*n +: 8];
        if (o_ren) dout <= mem[o_raddr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                            output logic [3:0] wen, output logic [31:0] din, output logic [8:0] wa);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = s; addr = a; wdata = d;
        #1;
        wen = o_wen; din = o_din; wa = o_waddr;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    // lat counts edges from the accept edge (1) to the edge that raises o_rvalid.
    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                           output logic [31:0] data, output int lat);
        logic seen;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = s; uns = u; addr = a;
        @(posedge clk);
        #1 req = 1'b0;
        lat = -1; data = 32'h0; seen = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (o_rvalid) begin seen = 1'b1; lat = i; data = o_rdata; end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h12345678;
        #1;
        chk("rst_wen", {28'h0, o_wen}, 32'h0);
        chk("rst_ren", {31'h0, o_ren}, 32'h0);
        chk("rst_rvalid", {31'h0, o_rvalid}, 32'h0);
        chk("rst_err", {31'h0, o_err}, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_bram_rst", {31'h0, o_bram_rst}, 32'h1);
        chk("rst_ready", {31'h0, o_ready}, 32'h1);
        req = 1'b0;
        @(negedge clk) rst = 1'b1;
        #1 chk("rel_bram_rst", {31'h0, o_bram_rst}, 32'h0);
    endtask

    task automatic test_word;
        logic [3:0] wen; logic [31:0] din, data; logic [8:0] wa; int lat;
        do_store(32'h10, 2'b10, 32'hDEADBEEF, wen, din, wa);
        chk("sw_wen", {28'h0, wen}, 32'hF);
        chk("sw_waddr", {23'h0, wa}, 32'd4);
        chk("sw_din", din, 32'hDEADBEEF);
        do_load(32'h10, 2'b10, 1'b0, data, lat);
        chk("lw_data", data, 32'hDEADBEEF);
        chk("lw_lat", lat, 32'd2);
        @(posedge clk); #1 chk("lw_rvalid_pulse", {31'h0, o_rvalid}, 32'h0);
        chk("lw_rdata_hold", o_rdata, 32'hDEADBEEF);
    endtask

    task automatic test_byte;
        logic [3:0] wen; logic [31:0] din, data; logic [8:0] wa; int lat;
        do_store(32'h13, 2'b00, 32'h000000A5, wen, din, wa);
        chk("sb_wen", {28'h0, wen}, 32'h8);
        chk("sb_din", din, 32'hA5A5A5A5);
        do_load(32'h13, 2'b00, 1'b0, data, lat);
        chk("lb_signed", data, 32'hFFFFFFA5);
        do_load(32'h13, 2'b00, 1'b1, data, lat);
        chk("lbu", data, 32'h000000A5);
        do_load(32'h10, 2'b10, 1'b0, data, lat);
        chk("lw_merged", data, 32'hA5ADBEEF);
        do_load(32'h11, 2'b00, 1'b1, data, lat);
        chk("lbu_lane1", data, 32'h000000BE);
    endtask

    task automatic test_half;
        logic [3:0] wen; logic [31:0] din, data; logic [8:0] wa; int lat;
        do_store(32'h22, 2'b01, 32'h00008001, wen, din, wa);
        chk("sh_wen", {28'h0, wen}, 32'hC);
        chk("sh_din", din, 32'h80018001);
        chk("sh_waddr", {23'h0, wa}, 32'd8);
        do_load(32'h22, 2'b01, 1'b1, data, lat);
        chk("lhu", data, 32'h00008001);
        do_load(32'h22, 2'b01, 1'b0, data, lat);
        chk("lh_signed", data, 32'hFFFF8001);
        do_load(32'h23, 2'b00, 1'b0, data, lat);
        chk("lb_lane3", data, 32'hFFFFFF80);
    endtask

    task automatic test_errors;
        logic        ev_we [3]   = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  ev_sz [3]   = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ev_ad [3]   = '{32'h12, 32'h21, 32'h0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 1'b1; we = ev_we[i]; size = ev_sz[i]; addr = ev_ad[i]; wdata = 32'hFFFFFFFF;
            #1;
            chk($sformatf("err%0d_wen", i), {28'h0, o_wen}, 32'h0);
            chk($sformatf("err%0d_ren", i), {31'h0, o_ren}, 32'h0);
            @(posedge clk);
            #1 req = 1'b0;
            chk($sformatf("err%0d_err", i), {31'h0, o_err}, 32'h1);
            chk($sformatf("err%0d_ready", i), {31'h0, o_ready}, 32'h1);
            @(posedge clk); #1;
            chk($sformatf("err%0d_pulse", i), {30'h0, o_err, o_rvalid}, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] wen; logic [31:0] din, data; logic [8:0] wa; int lat;
        do_store(32'h0, 2'b10, 32'h11111111, wen, din, wa);
        do_store(32'h4, 2'b10, 32'h22222222, wen, din, wa);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h800;
        #1;
        chk("b2b_ready0", {31'h0, o_ready}, 32'h1);
        chk("b2b_raddr_wrap", {23'h0, o_raddr}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_ready1", {31'h0, o_ready}, 32'h0);
        chk("b2b_ren_wait", {31'h0, o_ren}, 32'h0);
        addr = 32'h4;
        @(posedge clk); #1;
        chk("b2b_ready2", {31'h0, o_ready}, 32'h1);
        chk("b2b_first", {o_rvalid ? o_rdata : 32'hX}, 32'h11111111);
        chk("b2b_raddr2", {23'h0, o_raddr}, 32'h1);
        @(posedge clk); #1;
        req = 1'b0;
        chk("b2b_ready3", {31'h0, o_ready}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_second", {o_rvalid ? o_rdata : 32'hX}, 32'h22222222);
        // Store issued while the load result is being presented.
        we = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'h33333333; req = 1'b1;
        #1 chk("st_on_rvalid_wen", {28'h0, o_wen}, 32'hF);
        @(posedge clk); #1 req = 1'b0;
        do_load(32'h8, 2'b10, 1'b0, data, lat);
        chk("st_on_rvalid_data", data, 32'h33333333);
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] data; int lat;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
        @(posedge clk); #1 req = 1'b0;
        chk("rw_in_wait", {31'h0, o_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rw_ready", {31'h0, o_ready}, 32'h1);
        chk("rw_rdata", o_rdata, 32'h0);
        @(posedge clk); #1;
        chk("rw_no_rvalid", {31'h0, o_rvalid}, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rw_no_rvalid2", {31'h0, o_rvalid}, 32'h0);
        do_load(32'h4, 2'b10, 1'b0, data, lat);
        chk("rw_after_data", data, 32'h22222222);
        chk("rw_after_lat", lat, 32'd2);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        dout = 32'h0;
        repeat (2) @(posedge clk);
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_back_to_back;
        test_reset_in_wait;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the MIPS MEM stage and the data-memory byte-enable BRAM. It turns CPU byte-addressed load/store requests into BRAM word accesses: byte-write enables and replicated store data on the write port, and read enable on the read port. It absorbs the BRAM's one-cycle registered read latency and returns aligned, sign- or zero-extended load data. Misaligned or illegal-size accesses are flagged instead of reaching memory.

## Interface
Parameters:
- RAM_DEPTH, 512, BRAM depth in 32-bit words; RAM address width RAW = clogb2(RAM_DEPTH-1) (9 at default).
- ADDR_WIDTH, 32, CPU byte-address width.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_req  in  1  CPU request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_addr  in  ADDR_WIDTH  byte address.
- i_wdata  in  32  store data, right-justified.
- o_rvalid  out  1  one-cycle pulse: o_rdata holds a load result.
- o_rdata  out  32  aligned and extended load data.
- o_err  out  1  one-cycle pulse: the accepted access was misaligned or illegal.
- o_waddr  out  RAW  BRAM write word address.
- o_raddr  out  RAW  BRAM read word address.
- o_din  out  32  BRAM write data.
- o_wen  out  4  BRAM byte-write enables; bit n drives byte lane n, bits [8n+7:8n].
- o_ren  out  1  BRAM read enable.
- o_bram_rst  out  1  BRAM output reset, = ~i_rst.
- i_dout  in  32  BRAM registered read data, valid the cycle after o_ren.

## Operation
- Accept: i_req & o_ready & i_rst high. Sampled data is byte lane off = i_addr[1:0] and word index = i_addr[RAW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*RAM_DEPTH bytes.
- Legality: byte is always legal. Half requires off[0]=0. Word requires off=00. Size 11 is illegal.
- A misaligned or illegal access is not forwarded: o_wen=0 and o_ren=0. o_err pulses the following cycle. o_ready stays 1.
- Stores drive the BRAM combinationally in the accept cycle and produce no response:
  - byte: o_wen = 1<<off, o_din = {4{i_wdata[7:0]}}
  - half: o_wen = off[1] ? 1100 : 0011, o_din = {2{i_wdata[15:0]}}
  - word: o_wen = 1111, o_din = i_wdata
  - o_waddr = word index.
- Loads drive o_ren=1 and o_raddr=word index combinationally in the accept cycle. The unit registers off, size and unsigned, then moves to RD_WAIT.
- FSM:
  - IDLE: o_ready=1. A legal load moves to RD_WAIT. Stores and errors stay in IDLE.
  - RD_WAIT: o_ready=0 and o_ren=0. On the next edge, o_rdata <= extend(i_dout >> 8*off), truncated to the registered size; o_rvalid <= 1; go to IDLE.
- o_rdata holds its value until the next load result. o_rvalid and o_err are each high for exactly one cycle.
- All BRAM enables are forced to 0 while i_rst is low.

## Timing
- Reset values: state IDLE, o_rvalid 0, o_err 0, o_rdata 0, o_wen 0, o_ren 0, o_bram_rst 1. o_ready reads 1 in IDLE, but requests are ignored while i_rst is low.
- Store: commits to the BRAM at the accept edge. Throughput is one store per cycle.
- Load: accept edge k reads the BRAM. o_rvalid is high in the cycle after edge k+1 (latency 2). Maximum load throughput is one load every 2 cycles; o_ready pattern under a held load request is 1,0,1,0.
- A store at edge k followed by a load of the same word at edge k+1 returns the new data. No forwarding is required.
- A store is accepted in the same cycle that o_rvalid pulses for the previous load.
- Reset asserted in RD_WAIT: go to IDLE immediately. No o_rvalid pulse follows and the pending load is dropped.
- o_err for an access accepted at edge k is high in the cycle after edge k.

## Test plan
- Store word 0xDEADBEEF at 0x10 -> o_wen=1111, o_waddr=4, o_din=0xDEADBEEF. Then load word 0x10 -> o_rvalid 2 edges after accept, o_rdata=0xDEADBEEF.
- Store byte 0xA5 at 0x13 -> o_wen=1000, o_din=0xA5A5A5A5. Then signed byte load 0x13 -> 0xFFFFFFA5; unsigned byte load 0x13 -> 0x000000A5.
- Store half 0x8001 at 0x22 -> o_wen=1100, o_din=0x80018001. Then unsigned half load 0x22 -> 0x00008001; signed half load 0x22 -> 0xFFFF8001.
- Word load at 0x12, half store at 0x21, and size 11 -> each gives o_wen=0, o_ren=0, an o_err pulse one cycle later, no o_rvalid, and o_ready held at 1.
- Held back-to-back load requests to 0x800 and 0x4 (RAM_DEPTH 512) -> o_ready pattern 1,0,1. The 0x800 load uses o_raddr=0 (wrap). The two results arrive in order.
- Assert i_rst during RD_WAIT -> no o_rvalid pulse, o_rdata=0. After release, o_ready=1 and a new load completes normally.
